// File: rtl/edram_refresh_scheduler.sv
// Retention refresh sequencer for 16 eDRAM banks: per-bank retention
// counters, round-robin due-bank pick, PMU wakeup, ref_req/ref_ack handshake.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   bank_retain         bank holds data and must be refreshed
//   bank_active_status  bank is ACTIVE (from the PMU)
//   ref_ack             refresh engine done pulse for ref_bank
//   request_wakeup      one-hot keep-awake request for the selected bank
//   ref_req, ref_bank   refresh request level and its bank index
//   due_mask            banks whose retention counter is saturated
//   busy                FSM not idle
//   wake_timeout_err    sticky: a wakeup did not complete in time
//   refresh_count       (REFRESH_COUNT_EN only) accepted refresh count
//
// Optional feature macro: REFRESH_COUNT_EN
module edram_refresh_scheduler #(
  parameter int NUM_BANKS          = 16,
  parameter int T_RETENTION_CYCLES = 4096,
  parameter int T_WAKE_TIMEOUT     = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] bank_retain,
  input  logic [NUM_BANKS-1:0] bank_active_status,
  input  logic                 ref_ack,
  output logic [NUM_BANKS-1:0] request_wakeup,
  output logic                 ref_req,
  output logic [3:0]           ref_bank,
  output logic [NUM_BANKS-1:0] due_mask,
  output logic                 busy,
  output logic                 wake_timeout_err
`ifdef REFRESH_COUNT_EN
  ,
  output logic [15:0]          refresh_count
`endif
);

  localparam int IW = 4;
  localparam int CW = (T_RETENTION_CYCLES > 1) ?
                      $clog2(T_RETENTION_CYCLES) : 1;
  localparam int WW = (T_WAKE_TIMEOUT > 1) ?
                      $clog2(T_WAKE_TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(T_RETENTION_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(T_WAKE_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAKE    = 2'd1;
  localparam logic [1:0] S_REFRESH = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] sel;
  logic [IW-1:0] rr_ptr;
  logic [WW-1:0] wake_timer;
  logic [CW-1:0] cnt [NUM_BANKS];

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;

  logic in_idle;
  logic in_wake;
  logic in_ref;
  logic sel_retain;
  logic sel_active;
  logic abort;
  logic ack_ok;
  logic wake_to;

  assign in_idle    = (state == S_IDLE);
  assign in_wake    = (state == S_WAKE);
  assign in_ref     = (state == S_REFRESH);
  assign sel_retain = bank_retain[sel];
  assign sel_active = bank_active_status[sel];

  // Losing retention on the selected bank cancels any work on it.
  assign abort   = !in_idle && !sel_retain;
  assign ack_ok  = in_ref && sel_retain && ref_ack;
  assign wake_to = in_wake && sel_retain && !sel_active &&
                   (wake_timer == WAKE_LAST);

  // Retention counters
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (!bank_retain[i]) begin
        cnt[i] <= '0;
      end else if (ack_ok && (sel == IW'(i))) begin
        cnt[i] <= '0;
      end else if (cnt[i] != CNT_MAX) begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
    assign due_mask[i] = (cnt[i] == CNT_MAX);
  end

  // First due bank at or after rr_ptr, wrapping 15 -> 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    scan_idx = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      scan_idx = rr_ptr + IW'(k);
      if (!pick_vld && due_mask[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      in_idle: begin
        if (pick_vld) begin
          state_nxt = bank_active_status[pick_idx] ?
                      S_REFRESH : S_WAKE;
        end
      end
      in_wake: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (sel_active) begin
          state_nxt = S_REFRESH;
        end else if (wake_to) begin
          state_nxt = S_IDLE;
        end
      end
      in_ref: begin
        if (abort || ack_ok) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      sel              <= '0;
      rr_ptr           <= '0;
      wake_timer       <= '0;
      wake_timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_idle && pick_vld) begin
        sel        <= pick_idx;
        rr_ptr     <= pick_idx + IW'(1);
        wake_timer <= '0;
      end
      if (in_wake) begin
        wake_timer <= wake_timer + WW'(1);
      end
      if (wake_to) begin
        wake_timeout_err <= 1'b1;
      end
    end
  end

`ifdef REFRESH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_count <= '0;
    end else if (ack_ok) begin
      refresh_count <= refresh_count + 16'd1;
    end
  end
`endif

  assign busy     = !in_idle;
  assign ref_req  = in_ref;
  assign ref_bank = in_ref ? sel : '0;

  // The bank is held awake for the whole wake + refresh window.
  assign request_wakeup = (in_wake || in_ref) ?
                          (NUM_BANKS'(1) << sel) : '0;

endmodule

// File: tb/tb_edram_refresh_scheduler.sv
// Scoreboard bench for edram_refresh_scheduler (retention 16, wake timeout 8).
// Grants/wakeups are checked by a monitor against queued expectations.
module tb_edram_refresh_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] bank_retain;
  logic [15:0] bank_active_status;
  logic        ref_ack;
  logic [15:0] request_wakeup;
  logic        ref_req;
  logic [3:0]  ref_bank;
  logic [15:0] due_mask;
  logic        busy;
  logic        wake_timeout_err;
`ifdef REFRESH_COUNT_EN
  logic [15:0] refresh_count;
`endif

  int n_run;
  int n_fail;
  int exp_grant[$];
  int exp_wake[$];
  logic prev_req;
  logic prev_wake;

  edram_refresh_scheduler #(
    .NUM_BANKS          (16),
    .T_RETENTION_CYCLES (16),
    .T_WAKE_TIMEOUT     (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bank_retain        (bank_retain),
    .bank_active_status (bank_active_status),
    .ref_ack            (ref_ack),
    .request_wakeup     (request_wakeup),
    .ref_req            (ref_req),
    .ref_bank           (ref_bank),
    .due_mask           (due_mask),
    .busy               (busy),
    .wake_timeout_err   (wake_timeout_err)
`ifdef REFRESH_COUNT_EN
    ,
    .refresh_count      (refresh_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(logic [15:0] r, logic [15:0] a);
    rst = 1'b1;
    ref_ack = 1'b0;
    bank_retain = r;
    bank_active_status = a;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(int lim);
    int n;
    n = 0;
    while (!ref_req && n < lim) begin
      tick();
      n++;
    end
    chk("req_wait", 32'(ref_req), 32'd1);
  endtask

  task automatic ack_once();
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    prev_req = 1'b0;
    prev_wake = 1'b0;
    rst = 1'b1;
    ref_ack = 1'b0;
    bank_retain = '0;
    bank_active_status = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_req = 1'b0;
          prev_wake = 1'b0;
        end else begin
          if (ref_req && !prev_req) begin
            if (exp_grant.size() == 0) begin
              chk("mon_grant_unexpected", 32'(ref_bank), 32'hFFFF);
            end else begin
              int b;
              b = exp_grant.pop_front();
              chk("mon_grant_bank", 32'(ref_bank), 32'(b));
              chk("mon_grant_wake", 32'(request_wakeup),
                  32'd1 << b);
            end
          end
          if (request_wakeup != 0 && !prev_wake && !ref_req) begin
            if (exp_wake.size() == 0) begin
              chk("mon_wake_unexpected", 32'(request_wakeup), 32'h0);
            end else begin
              int b;
              b = exp_wake.pop_front();
              chk("mon_wake_mask", 32'(request_wakeup),
                  32'd1 << b);
            end
          end
          prev_req = ref_req;
          prev_wake = (request_wakeup != 0);
        end
      end
    join_none

    // Reset state
    tick();
    chk("rst_req", 32'(ref_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_due", 32'(due_mask), 0);

    // Bank 3 retained and active from reset
    do_reset(16'h0008, 16'h0008);
    exp_grant.push_back(3);
    repeat (14) tick();
    chk("t1_due_early", 32'(due_mask), 0);
    tick();
    chk("t1_due", 32'(due_mask), 32'h8);
    chk("t1_req_pre", 32'(ref_req), 0);
    tick();
    chk("t1_req", 32'(ref_req), 1);
    chk("t1_bank", 32'(ref_bank), 3);
    chk("t1_busy", 32'(busy), 1);
    tick();
    ack_once();
    chk("t1_req_off", 32'(ref_req), 0);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_wake_off", 32'(request_wakeup), 0);
    chk("t1_cnt_clr", 32'(dut.cnt[3]), 0);
    ack_once();
    chk("t1_stray_ack_cnt", 32'(dut.cnt[3]), 1);
    chk("t1_stray_ack_busy", 32'(busy), 0);

    // Banks 2, 5, 9 together; then 2, 5, 9, 10 with pointer at 10
    do_reset(16'h0224, 16'hFFFF);
    exp_grant.push_back(2);
    exp_grant.push_back(5);
    exp_grant.push_back(9);
    repeat (15) tick();
    chk("t2_due", 32'(due_mask), 32'h0224);
    for (int i = 0; i < 3; i++) begin
      wait_req(40);
      ack_once();
    end
    bank_retain = 16'h0000;
    tick();
    bank_retain = 16'h0624;
    exp_grant.push_back(10);
    exp_grant.push_back(2);
    exp_grant.push_back(5);
    exp_grant.push_back(9);
    repeat (15) tick();
    chk("t2_due2", 32'(due_mask), 32'h0624);
    for (int i = 0; i < 4; i++) begin
      wait_req(40);
      ack_once();
    end

    // Bank 7 must be woken first
    do_reset(16'h0080, 16'h0000);
    exp_wake.push_back(7);
    exp_grant.push_back(7);
    repeat (16) tick();
    chk("t3_wake", 32'(request_wakeup), 32'h80);
    chk("t3_no_req", 32'(ref_req), 0);
    chk("t3_busy", 32'(busy), 1);
    repeat (4) tick();
    chk("t3_still_wake", 32'(ref_req), 0);
    bank_active_status = 16'h0080;
    tick();
    chk("t3_req", 32'(ref_req), 1);
    chk("t3_bank", 32'(ref_bank), 7);
    bank_active_status = 16'h0000;
    tick();
    chk("t3_req_held", 32'(ref_req), 1);
    chk("t3_wake_held", 32'(request_wakeup), 32'h80);
    ack_once();
    chk("t3_req_off", 32'(ref_req), 0);
    chk("t3_wake_off", 32'(request_wakeup), 0);
    chk("t3_no_err", 32'(wake_timeout_err), 0);

    // Bank 7 never wakes
    do_reset(16'h0080, 16'h0000);
    exp_wake.push_back(7);
    exp_wake.push_back(7);
    repeat (23) tick();
    chk("t4_busy", 32'(busy), 1);
    chk("t4_err_pre", 32'(wake_timeout_err), 0);
    tick();
    chk("t4_err", 32'(wake_timeout_err), 1);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_wake_off", 32'(request_wakeup), 0);
    tick();
    chk("t4_reselect", 32'(request_wakeup), 32'h80);
    bank_retain = 16'h0000;
    tick();
    chk("t4_abort_busy", 32'(busy), 0);
    chk("t4_err_sticky", 32'(wake_timeout_err), 1);

    // Bank 4 in refresh: retain drop, then reset, then counted acks
    do_reset(16'h0010, 16'h0010);
    chk("t5_err_clr", 32'(wake_timeout_err), 0);
    exp_grant.push_back(4);
    repeat (16) tick();
    chk("t5_req", 32'(ref_req), 1);
    chk("t5_bank", 32'(ref_bank), 4);
    bank_retain = 16'h0000;
    tick();
    chk("t5_abort_req", 32'(ref_req), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_err", 32'(wake_timeout_err), 0);
    bank_retain = 16'h0010;
    exp_grant.push_back(4);
    wait_req(40);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_req", 32'(ref_req), 0);
    chk("t5_rst_wake", 32'(request_wakeup), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_bank", 32'(ref_bank), 0);
    chk("t5_rst_due", 32'(due_mask), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back(4);
    end
    for (int i = 0; i < 3; i++) begin
      wait_req(40);
      ack_once();
    end
`ifdef REFRESH_COUNT_EN
    chk("t5_refresh_count", 32'(refresh_count), 3);
`endif
    chk("t5_err_final", 32'(wake_timeout_err), 0);

    tick();
    chk("grant_q_empty", 32'(exp_grant.size()), 0);
    chk("wake_q_empty", 32'(exp_wake.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
